// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    localparam logic [6:0]  DEFAULT_ADDR  = 7'h60;
    localparam logic [15:0] ADDR_SENTINEL = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REGH,
        REGH_ACK,
        REGL,
        REGL_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MST_ACK,
        IGNORE
    } i2c_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  val;
    } reg_write_t;

    // Register pointer advance; the top of the map wraps back to zero.
    function automatic logic [15:0] next_addr(input logic [15:0] a);
        return (a == ADDR_SENTINEL) ? 16'h0000 : a + 16'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the i_clk domain and flags SCL edges, START and STOP.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Shift registers preset high so a released bus never looks like a START.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], i_scl};
            sda_q <= {sda_q[1:0], i_sda};
        end
    end

    assign o_sda      = sda_q[1];
    assign o_scl_rise = scl_q[1] & ~scl_q[2];
    assign o_scl_fall = ~scl_q[1] & scl_q[2];
    assign o_start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign o_stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target bridging a 16-bit register pointer and byte data to a reg-file port.
//
// state     | meaning
// IDLE      | bus ignored until START
// DEV_ADDR  | shifting in device address + R/W
// DEV_ACK   | acknowledging matched address
// REGH      | shifting in pointer high byte
// REGH_ACK  | acknowledging pointer high byte
// REGL      | shifting in pointer low byte
// REGL_ACK  | acknowledging pointer low byte
// WDATA     | shifting in write data
// WDATA_ACK | acknowledging write data
// RDATA     | fetching and shifting out read data
// MST_ACK   | SDA released, sampling controller ACK/NACK
// IGNORE    | not addressed or NACKed; wait for START/STOP
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = DEFAULT_ADDR,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scl_in,
    input  logic        i_sda_in,
    output logic        o_scl_oe,
    output logic        o_sda_oe,
    output logic        o_scl_out,
    output logic        o_sda_out,
    output logic        o_busy,
    output logic        o_reg_wr,
    output logic [15:0] o_reg_addr,
    output logic [7:0]  o_reg_wdata,
    output logic        o_reg_rd,
    input  logic [7:0]  i_reg_rdata
);

    // Loaded with RD_LAT+1 alongside the read strobe; terminal count 1 marks capture.
    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT + 1);

    i2c_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic        ack_seen_q, ack_seen_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        reg_wr_q, reg_wr_d;
    logic        reg_rd_q, reg_rd_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    i2c_bus_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl_in),
        .i_sda      (i_sda_in),
        .o_sda      (sda_s),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (start_det),
        .o_stop     (stop_det)
    );

    assign rx_byte = {rx_q[6:0], sda_s};

    // Next-state, bit handling, strobes and SDA drive decisions.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        ack_seen_d = ack_seen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        reg_wr_d   = 1'b0;
        reg_rd_d   = 1'b0;
        lat_cnt_d  = (lat_cnt_q != 4'd0) ? lat_cnt_q - 4'd1 : 4'd0;

        if (reg_wr_q) addr_d = next_addr(addr_q);

        // Read data arrives: bit 7 goes out straight away, pointer moves on.
        if (state_q == RDATA && lat_cnt_q == 4'd1) begin
            tx_d     = i_reg_rdata;
            sda_oe_d = ~i_reg_rdata[7];
            addr_d   = next_addr(addr_q);
        end

        case (state_q)
            DEV_ADDR, REGH, REGL, WDATA: begin
                if (scl_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == DEV_ADDR) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                state_d = DEV_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == REGH) begin
                            addr_d[15:8] = rx_byte;
                            state_d      = REGH_ACK;
                        end else if (state_q == REGL) begin
                            addr_d[7:0] = rx_byte;
                            state_d     = REGL_ACK;
                        end else begin
                            wdata_d  = rx_byte;
                            reg_wr_d = 1'b1;
                            state_d  = WDATA_ACK;
                        end
                    end
                end
            end
            // First fall after the 8th bit pulls SDA low, the next one ends the ACK.
            DEV_ACK, REGH_ACK, REGL_ACK, WDATA_ACK: begin
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        if (state_q == DEV_ACK) begin
                            if (rw_q) begin
                                state_d   = RDATA;
                                reg_rd_d  = 1'b1;
                                lat_cnt_d = LAT_LOAD;
                            end else begin
                                state_d = REGH;
                            end
                        end else if (state_q == REGH_ACK) begin
                            state_d = REGL;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end
            RDATA: begin
                if (scl_fall) begin
                    tx_d     = {tx_q[6:0], 1'b0};
                    sda_oe_d = ~tx_q[6];
                end
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d    = MST_ACK;
                        ack_seen_d = 1'b0;
                    end
                end
            end
            MST_ACK: begin
                if (scl_rise) begin
                    if (sda_s) begin
                        state_d = IGNORE;
                        busy_d  = 1'b0;
                    end else begin
                        ack_seen_d = 1'b1;
                    end
                end
                if (scl_fall) begin
                    if (!ack_seen_q) begin
                        sda_oe_d = 1'b0;
                    end else begin
                        ack_seen_d = 1'b0;
                        state_d    = RDATA;
                        reg_rd_d   = 1'b1;
                        lat_cnt_d  = LAT_LOAD;
                    end
                end
            end
            default: ;
        endcase

        // START/STOP override everything and drop any partial byte or pending fetch.
        if (start_det || stop_det) begin
            state_d    = start_det ? DEV_ADDR : IDLE;
            bit_cnt_d  = 3'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_seen_d = 1'b0;
            lat_cnt_d  = 4'd0;
            reg_wr_d   = 1'b0;
            reg_rd_d   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            reg_wr_q   <= 1'b0;
            reg_rd_q   <= 1'b0;
            lat_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ack_seen_q <= ack_seen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            reg_wr_q   <= reg_wr_d;
            reg_rd_q   <= reg_rd_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign o_scl_oe    = 1'b0;
    assign o_scl_out   = 1'b0;
    assign o_sda_out   = 1'b0;
    assign o_sda_oe    = sda_oe_q;
    assign o_busy      = busy_q;
    assign o_reg_wr    = reg_wr_q;
    assign o_reg_rd    = reg_rd_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged controller, reg-file model, write log.
module tb_i2c_reg_target;
    import i2c_pkg::*;

    localparam int RD_LAT = 2;
    localparam int Q      = 6;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        i_scl_in, i_sda_in;
    logic        o_scl_oe, o_sda_oe, o_scl_out, o_sda_out, o_busy, o_reg_wr, o_reg_rd;
    logic [15:0] o_reg_addr;
    logic [7:0]  o_reg_wdata;
    logic [7:0]  i_reg_rdata;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mem [0:65535];
    reg_write_t  wr_log[$];
    int          rd_cnt = 0;
    int          since = -1;
    logic [15:0] raddr = 16'h0000;
    bit          busy_seen = 1'b0;
    bit          oe_seen = 1'b0;

    always #5 i_clk = ~i_clk;

    assign i_scl_in = scl_m;
    assign i_sda_in = sda_m & ~o_sda_oe;

    i2c_reg_target #(.TARGET_ADDR(7'h60), .RD_LAT(RD_LAT)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_scl_in    (i_scl_in),
        .i_sda_in    (i_sda_in),
        .o_scl_oe    (o_scl_oe),
        .o_sda_oe    (o_sda_oe),
        .o_scl_out   (o_scl_out),
        .o_sda_out   (o_sda_out),
        .o_busy      (o_busy),
        .o_reg_wr    (o_reg_wr),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_rd    (o_reg_rd),
        .i_reg_rdata (i_reg_rdata)
    );

    // Reg-file model: logs writes, returns data exactly RD_LAT cycles after a read strobe.
    always @(negedge i_clk) begin
        if (o_reg_wr) begin
            wr_log.push_back('{addr: o_reg_addr, val: o_reg_wdata});
            mem[o_reg_addr] = o_reg_wdata;
        end
        if (o_reg_rd) begin
            rd_cnt++;
            since = 0;
            raddr = o_reg_addr;
        end else if (since >= 0 && since < 1000) begin
            since++;
        end
        i_reg_rdata = (since == RD_LAT) ? mem[raddr] : 8'($urandom);
        if (o_busy)   busy_seen = 1'b1;
        if (o_sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qw();
        repeat (Q) @(negedge i_clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; qw();
        scl_m = 1'b1; qw(); qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = i_sda_in; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(input logic last, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(last);
    endtask

    task automatic txn_write(input logic [15:0] ptr, input logic [7:0] d [4], input int n);
        logic ack;
        i2c_start();
        wbyte(8'hC0, ack);      chk("wr_dev_ack", 32'(ack), 1);
        wbyte(ptr[15:8], ack);  chk("wr_ptrh_ack", 32'(ack), 1);
        wbyte(ptr[7:0], ack);   chk("wr_ptrl_ack", 32'(ack), 1);
        for (int i = 0; i < n; i++) begin
            wbyte(d[i], ack);   chk("wr_data_ack", 32'(ack), 1);
        end
        i2c_stop();
    endtask

    task automatic txn_read(input logic [15:0] ptr, input int n, output logic [7:0] r [4]);
        logic ack;
        i2c_start();
        wbyte(8'hC0, ack);      chk("rd_dev_w_ack", 32'(ack), 1);
        wbyte(ptr[15:8], ack);  chk("rd_ptrh_ack", 32'(ack), 1);
        wbyte(ptr[7:0], ack);   chk("rd_ptrl_ack", 32'(ack), 1);
        i2c_start();
        wbyte(8'hC1, ack);      chk("rd_dev_r_ack", 32'(ack), 1);
        for (int i = 0; i < n; i++) rbyte(i == n - 1, r[i]);
        i2c_stop();
    endtask

    logic [7:0]  d [4];
    logic [7:0]  r [4];
    logic        ack, b;
    int          n, rd0;
    logic [15:0] ptr;

    initial begin
        // Reset values
        repeat (3) @(negedge i_clk);
        chk("rst_sda_oe", 32'(o_sda_oe), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_wr", 32'(o_reg_wr), 0);
        chk("rst_rd", 32'(o_reg_rd), 0);
        chk("rst_addr", 32'(o_reg_addr), 0);
        chk("rst_wdata", 32'(o_reg_wdata), 0);
        chk("scl_oe_tied", 32'(o_scl_oe), 0);
        chk("outs_tied", {30'd0, o_scl_out, o_sda_out}, 0);
        i_rst_n = 1'b1;
        qw();

        // Two-byte write with auto-increment
        wr_log.delete();
        i2c_start();
        wbyte(8'hC0, ack); chk("w_dev_ack", 32'(ack), 1);
        chk("busy_after_match", 32'(o_busy), 1);
        wbyte(8'h30, ack); chk("w_h_ack", 32'(ack), 1);
        wbyte(8'h0A, ack); chk("w_l_ack", 32'(ack), 1);
        wbyte(8'h92, ack); chk("w_d0_ack", 32'(ack), 1);
        wbyte(8'h81, ack); chk("w_d1_ack", 32'(ack), 1);
        i2c_stop();
        chk("busy_after_stop", 32'(o_busy), 0);
        chk("w_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("w0", 32'(wr_log[0]), 32'({16'h300A, 8'h92}));
            chk("w1", 32'(wr_log[1]), 32'({16'h300B, 8'h81}));
        end

        // Pointer write, repeated START, two-byte read
        mem[16'h300A] = 8'h92;
        mem[16'h300B] = 8'h81;
        wr_log.delete();
        rd0 = rd_cnt;
        txn_read(16'h300A, 2, r);
        chk("r0", 32'(r[0]), 32'h92);
        chk("r1", 32'(r[1]), 32'h81);
        chk("r_strobes", rd_cnt - rd0, 2);
        chk("r_no_writes", wr_log.size(), 0);

        // Foreign address is NACKed and ignored
        busy_seen = 1'b0;
        rd0 = rd_cnt;
        i2c_start();
        wbyte(8'hA0, ack); chk("foreign_nack", 32'(ack), 0);
        wbyte(8'h55, ack); chk("ignore_nack", 32'(ack), 0);
        i2c_stop();
        chk("foreign_busy", 32'(busy_seen), 0);
        chk("foreign_wr", wr_log.size(), 0);
        chk("foreign_rd", rd_cnt - rd0, 0);
        i2c_start();
        wbyte(8'hC0, ack); chk("after_foreign_ack", 32'(ack), 1);
        i2c_stop();

        // Pointer wrap
        wr_log.delete();
        d[0] = 8'hA5; d[1] = 8'h5A;
        txn_write(16'hFFFF, d, 2);
        chk("wrap_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("wrap0", 32'(wr_log[0]), 32'({16'hFFFF, 8'hA5}));
            chk("wrap1", 32'(wr_log[1]), 32'({16'h0000, 8'h5A}));
        end

        // STOP after 4 data bits
        wr_log.delete();
        i2c_start();
        wbyte(8'hC0, ack);
        wbyte(8'h12, ack);
        wbyte(8'h34, ack);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        i2c_stop();
        qw();
        chk("partial_no_wr", wr_log.size(), 0);
        chk("partial_busy", 32'(o_busy), 0);
        oe_seen = 1'b0;
        wbyte(8'hC0, ack);
        chk("partial_idle_no_ack", 32'(ack), 0);
        chk("partial_idle_oe", 32'(oe_seen), 0);
        i2c_stop();

        // Reset during read bit 3 (0x55: bit 3 is 0, so SDA is being driven)
        mem[16'h4242] = 8'h55;
        i2c_start();
        wbyte(8'hC0, ack);
        wbyte(8'h42, ack);
        wbyte(8'h42, ack);
        i2c_start();
        wbyte(8'hC1, ack); chk("rst_rd_ack", 32'(ack), 1);
        for (int i = 0; i < 4; i++) rbit(b);
        chk("bit3_driven", 32'(o_sda_oe), 1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1 chk("rst_release_sda", 32'(o_sda_oe), 0);
        chk("rst_mid_addr", 32'(o_reg_addr), 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        wbyte(8'hC0, ack);
        chk("post_rst_no_ack", 32'(ack), 0);
        chk("post_rst_oe", 32'(oe_seen), 0);
        chk("post_rst_busy", 32'(busy_seen), 0);
        i2c_stop();
        wr_log.delete();
        d[0] = 8'h3C;
        txn_write(16'h1234, d, 1);
        chk("post_rst_wr", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("post_rst_w0", 32'(wr_log[0]), 32'({16'h1234, 8'h3C}));

        // Randomized write then read-back against the model
        for (int it = 0; it < 6; it++) begin
            ptr = (it % 3 == 0) ? 16'hFFFE : 16'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                d[i] = 8'($urandom);
                mem[16'((32'(ptr) + i) % 65536)] = ~d[i];
            end
            wr_log.delete();
            txn_write(ptr, d, n);
            chk("rnd_wr_count", wr_log.size(), n);
            for (int i = 0; i < n && i < wr_log.size(); i++)
                chk("rnd_wr", 32'(wr_log[i]), {8'd0, 16'((32'(ptr) + i) % 65536), d[i]});
            rd0 = rd_cnt;
            txn_read(ptr, n, r);
            chk("rnd_rd_strobes", rd_cnt - rd0, n);
            for (int i = 0; i < n; i++) chk("rnd_rd", 32'(r[i]), 32'(d[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
